// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for a simple
// single-bus datapath. States IDLE, T0..T5 and HALT; every strobe is a
// register loaded on the edge that enters the state it belongs to, so
// each strobe is stable for the whole cycle and clears asynchronously
// with the state register.
//
// mem_ready is sampled on every edge that enters or stays in T1. The T1
// cycle that follows an edge with mem_ready=1 is the final fetch cycle:
// it adds Zlowout/PCin, and the next edge always moves on to T2. This is
// what limits PCin to a single cycle per fetch however long memory
// stalls.
module control_unit (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic        mem_ready,
   input  logic [31:0] IR,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zlowout,
   output logic        read,
   output logic [15:0] R_in,
   output logic [15:0] R_out,
   output logic [4:0]  ALU,
   output logic        running,
   output logic        halted,
   output logic        illegal
);

   localparam int unsigned OP_W  = 5;
   localparam int unsigned REG_W = 4;
   localparam int unsigned NREG  = 16;
   localparam int unsigned ALU_W = 5;

   localparam logic [OP_W-1:0]  OP_R_FIRST = 5'b00011;
   localparam logic [OP_W-1:0]  OP_R_LAST  = 5'b01111;
   localparam logic [OP_W-1:0]  OP_NOP     = 5'b11000;
   localparam logic [OP_W-1:0]  OP_HALT    = 5'b11011;
   localparam logic [ALU_W-1:0] ALU_BIAS   = 5'b00010;
   localparam logic [NREG-1:0]  REG_ONE    = 16'h0001;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   state_t state;
   state_t state_nx;

   // set while in the final T1 cycle of a fetch (memory data accepted)
   logic fetch_done;
   logic fetch_done_nx;

   // instruction fields
   logic [OP_W-1:0]  opcode;
   logic [REG_W-1:0] ra;
   logic [REG_W-1:0] rb;
   logic [REG_W-1:0] rc;
   logic             is_rtype;
   logic             is_nop;
   logic             is_halt;
   logic [ALU_W-1:0] alu_code;
   logic             unused_ir_bits;

   // next-cycle values of the registered outputs
   logic             pc_out_nx;
   logic             pc_in_nx;
   logic             inc_pc_nx;
   logic             mar_in_nx;
   logic             mdr_in_nx;
   logic             mdr_out_nx;
   logic             ir_in_nx;
   logic             y_in_nx;
   logic             zlow_in_nx;
   logic             zlow_out_nx;
   logic             read_nx;
   logic [NREG-1:0]  r_in_nx;
   logic [NREG-1:0]  r_out_nx;
   logic [ALU_W-1:0] alu_nx;
   logic             running_nx;
   logic             halted_nx;
   logic             illegal_nx;

   // field extraction and opcode classification
   assign opcode         = IR[31:27];
   assign ra             = IR[26:23];
   assign rb             = IR[22:19];
   assign rc             = IR[18:15];
   assign unused_ir_bits = ^IR[14:0];
   assign is_rtype       = (opcode >= OP_R_FIRST) && (opcode <= OP_R_LAST);
   assign is_nop         = (opcode == OP_NOP);
   assign is_halt        = (opcode == OP_HALT);
   assign alu_code       = ALU_W'(opcode - ALU_BIAS);

   // next-state selection and fetch-completion tracking
   always_comb begin
      state_nx      = state;
      fetch_done_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) state_nx = S_T0;
         end
         S_T0: begin
            state_nx      = S_T1;
            fetch_done_nx = mem_ready;
         end
         S_T1: begin
            if (fetch_done) begin
               state_nx = S_T2;
            end else begin
               state_nx      = S_T1;
               fetch_done_nx = mem_ready;
            end
         end
         S_T2: begin
            state_nx = S_T3;
         end
         S_T3: begin
            if (is_rtype)     state_nx = S_T4;
            else if (is_halt) state_nx = S_HALT;
            else              state_nx = S_T0;
         end
         S_T4: begin
            state_nx = S_T5;
         end
         S_T5: begin
            state_nx = S_T0;
         end
         S_HALT: begin
            if (run) state_nx = S_T0;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // strobe decode for the state being entered
   always_comb begin
      pc_out_nx   = 1'b0;
      pc_in_nx    = 1'b0;
      inc_pc_nx   = 1'b0;
      mar_in_nx   = 1'b0;
      mdr_in_nx   = 1'b0;
      mdr_out_nx  = 1'b0;
      ir_in_nx    = 1'b0;
      y_in_nx     = 1'b0;
      zlow_in_nx  = 1'b0;
      zlow_out_nx = 1'b0;
      read_nx     = 1'b0;
      r_in_nx     = '0;
      r_out_nx    = '0;
      alu_nx      = '0;
      running_nx  = 1'b0;
      halted_nx   = 1'b0;
      illegal_nx  = 1'b0;
      case (state_nx)
         S_T0: begin
            pc_out_nx  = 1'b1;
            mar_in_nx  = 1'b1;
            inc_pc_nx  = 1'b1;
            zlow_in_nx = 1'b1;
            running_nx = 1'b1;
         end
         S_T1: begin
            read_nx    = 1'b1;
            mdr_in_nx  = 1'b1;
            running_nx = 1'b1;
            if (fetch_done_nx) begin
               zlow_out_nx = 1'b1;
               pc_in_nx    = 1'b1;
            end
         end
         S_T2: begin
            mdr_out_nx = 1'b1;
            ir_in_nx   = 1'b1;
            running_nx = 1'b1;
         end
         S_T3: begin
            running_nx = 1'b1;
            if (is_rtype) begin
               r_out_nx = REG_ONE << rb;
               y_in_nx  = 1'b1;
            end else if (!is_nop && !is_halt) begin
               illegal_nx = 1'b1;
            end
         end
         S_T4: begin
            running_nx = 1'b1;
            r_out_nx   = REG_ONE << rc;
            zlow_in_nx = 1'b1;
            alu_nx     = alu_code;
         end
         S_T5: begin
            running_nx  = 1'b1;
            zlow_out_nx = 1'b1;
            r_in_nx     = REG_ONE << ra;
            alu_nx      = alu_code;
         end
         S_HALT: begin
            halted_nx = 1'b1;
         end
         default: begin
            running_nx = 1'b0;
         end
      endcase
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state      <= S_IDLE;
         fetch_done <= 1'b0;
         PCout      <= 1'b0;
         PCin       <= 1'b0;
         IncPC      <= 1'b0;
         MARin      <= 1'b0;
         MDRin      <= 1'b0;
         MDRout     <= 1'b0;
         IRin       <= 1'b0;
         Yin        <= 1'b0;
         Zlowin     <= 1'b0;
         Zlowout    <= 1'b0;
         read       <= 1'b0;
         R_in       <= '0;
         R_out      <= '0;
         ALU        <= '0;
         running    <= 1'b0;
         halted     <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         state      <= state_nx;
         fetch_done <= fetch_done_nx;
         PCout      <= pc_out_nx;
         PCin       <= pc_in_nx;
         IncPC      <= inc_pc_nx;
         MARin      <= mar_in_nx;
         MDRin      <= mdr_in_nx;
         MDRout     <= mdr_out_nx;
         IRin       <= ir_in_nx;
         Yin        <= y_in_nx;
         Zlowin     <= zlow_in_nx;
         Zlowout    <= zlow_out_nx;
         read       <= read_nx;
         R_in       <= r_in_nx;
         R_out      <= r_out_nx;
         ALU        <= alu_nx;
         running    <= running_nx;
         halted     <= halted_nx;
         illegal    <= illegal_nx;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. The stimulus process
// walks instructions through a reference model that spells out, per
// instruction class, the strobes of every cycle and queues them; the
// monitor pops one expectation per cycle on the falling edge.
`timescale 1ns/1ps
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear;
   logic        run;
   logic        mem_ready;
   logic [31:0] IR;
   logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin;
   logic        Zlowin, Zlowout, read, running, halted, illegal;
   logic [15:0] R_in, R_out;
   logic [4:0]  ALU;

   control_unit dut (
      .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout),
      .read(read), .R_in(R_in), .R_out(R_out), .ALU(ALU), .running(running),
      .halted(halted), .illegal(illegal)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        pc_out;
      logic        pc_in;
      logic        inc_pc;
      logic        mar_in;
      logic        mdr_in;
      logic        mdr_out;
      logic        ir_in;
      logic        y_in;
      logic        zlow_in;
      logic        zlow_out;
      logic        rd;
      logic [15:0] r_in;
      logic [15:0] r_out;
      logic [4:0]  alu;
      logic        running;
      logic        halted;
      logic        illegal;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   obs_t mon_exp;
   obs_t mon_act;

   function automatic obs_t sample();
      obs_t o;
      o.pc_out = PCout;  o.pc_in = PCin;     o.inc_pc = IncPC;  o.mar_in = MARin;
      o.mdr_in = MDRin;  o.mdr_out = MDRout; o.ir_in = IRin;    o.y_in = Yin;
      o.zlow_in = Zlowin; o.zlow_out = Zlowout; o.rd = read;
      o.r_in = R_in;     o.r_out = R_out;    o.alu = ALU;
      o.running = running; o.halted = halted; o.illegal = illegal;
      return o;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // instruction class: 0 = register op, 1 = nop, 2 = halt, 3 = undefined
   function automatic int klass(input logic [31:0] ir);
      int op;
      op = int'(ir[31:27]);
      if (op >= 3 && op <= 15) return 0;
      if (op == 24) return 1;
      if (op == 27) return 2;
      return 3;
   endfunction

   function automatic obs_t quiet();
      obs_t o;
      o = '0;
      return o;
   endfunction

   function automatic obs_t t0_o();
      obs_t o;
      o = '0;
      o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.zlow_in = 1'b1;
      o.running = 1'b1;
      return o;
   endfunction

   function automatic obs_t t1_o(input bit last);
      obs_t o;
      o = '0;
      o.rd = 1'b1; o.mdr_in = 1'b1; o.running = 1'b1;
      o.pc_in = last; o.zlow_out = last;
      return o;
   endfunction

   function automatic obs_t t2_o();
      obs_t o;
      o = '0;
      o.mdr_out = 1'b1; o.ir_in = 1'b1; o.running = 1'b1;
      return o;
   endfunction

   function automatic obs_t t3_o(input logic [31:0] ir);
      obs_t o;
      o = '0;
      o.running = 1'b1;
      if (klass(ir) == 0) begin
         o.r_out = 16'(1 << int'(ir[22:19]));
         o.y_in  = 1'b1;
      end else if (klass(ir) == 3) begin
         o.illegal = 1'b1;
      end
      return o;
   endfunction

   function automatic obs_t t4_o(input logic [31:0] ir);
      obs_t o;
      o = '0;
      o.running = 1'b1; o.zlow_in = 1'b1;
      o.r_out = 16'(1 << int'(ir[18:15]));
      o.alu   = 5'(int'(ir[31:27]) - 2);
      return o;
   endfunction

   function automatic obs_t t5_o(input logic [31:0] ir);
      obs_t o;
      o = '0;
      o.running = 1'b1; o.zlow_out = 1'b1;
      o.r_in = 16'(1 << int'(ir[26:23]));
      o.alu  = 5'(int'(ir[31:27]) - 2);
      return o;
   endfunction

   function automatic obs_t halt_o();
      obs_t o;
      o = '0;
      o.halted = 1'b1;
      return o;
   endfunction

   // ---------------- stimulus ----------------
   // one clock edge; queue what the cycle it starts must show
   task automatic tick(input obs_t e);
      @(posedge clock);
      #1;
      exp_q.push_back(e);
   endtask

   // runs one instruction; entered and left at the start of a T0 cycle
   task automatic exec_instr(input logic [31:0] ir, input int nwait);
      IR  = ir;
      run = 1'($urandom);
      for (int k = 0; k <= nwait; k++) begin
         mem_ready = (k == nwait);
         tick(t1_o(k == nwait));
         run = 1'($urandom);
      end
      mem_ready = 1'($urandom);
      tick(t2_o());
      tick(t3_o(ir));
      case (klass(ir))
         0: begin
            tick(t4_o(ir));
            tick(t5_o(ir));
            tick(t0_o());
         end
         2: begin
            tick(halt_o());
            run = 1'b0;
            repeat ($urandom_range(0, 3)) tick(halt_o());
            run = 1'b1;
            tick(t0_o());
         end
         default: tick(t0_o());
      endcase
   endtask

   // runs a register op into T4, then pulls clear mid-cycle
   task automatic reset_in_t4(input logic [31:0] ir);
      IR        = ir;
      mem_ready = 1'b1;
      tick(t1_o(1'b1));
      tick(t2_o());
      tick(t3_o(ir));
      @(posedge clock);
      #1;
      exp_q.push_back(quiet());
      #1 clear = 1'b0;
      #1 check("clear_in_t4_async", sample(), quiet());
      run = 1'b0;
      tick(quiet());
      clear = 1'b1;
      repeat (3) tick(quiet());
      run = 1'b1;
      tick(t0_o());
   endtask

   // ---------------- monitor ----------------
   // compares one queued expectation per cycle plus the bus-driver rule
   always @(negedge clock) begin
      cyc++;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = sample();
         check($sformatf("cycle_%0d", cyc), mon_act, mon_exp);
         n_checks++;
         if ((int'(PCout) + int'(MDRout) + int'(Zlowout) + $countones(R_out)) <= 1 &&
             $countones(R_in) <= 1)
            n_pass++;
         else
            $display("FAIL bus_drivers cycle_%0d: R_out=%h R_in=%h PCout=%b MDRout=%b Zlowout=%b, required at most one driver",
                     cyc, R_out, R_in, PCout, MDRout, Zlowout);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ir;
      clear     = 1'b1;
      run       = 1'b0;
      mem_ready = 1'b0;
      IR        = '0;
      #2 clear = 1'b0;
      #1 check("reset_async", sample(), quiet());
      @(posedge clock);
      #1 clear = 1'b1;
      repeat (5) tick(quiet());
      run = 1'b1;
      tick(t0_o());

      exec_instr(32'h5332_0000, 0);   // ROR R6,R6,R4, no stall
      exec_instr(32'h5332_0000, 3);   // same with a three-cycle memory stall
      exec_instr(32'hD800_0000, 0);   // halt
      exec_instr(32'hF800_0000, 1);   // undefined opcode
      exec_instr(32'hC000_0000, 0);   // nop
      exec_instr(32'h1999_8000, 2);   // ra=rb=rc=3

      for (int i = 0; i < 40; i++) begin
         ir = $urandom;
         if ($urandom_range(0, 1) == 1) ir[31:27] = 5'($urandom_range(3, 15));
         exec_instr(ir, int'($urandom_range(0, 3)));
      end

      reset_in_t4(32'h7AB4_0000);
      for (int i = 0; i < 10; i++) begin
         ir = $urandom;
         exec_instr(ir, int'($urandom_range(0, 2)));
      end

      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port clear, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port run, input, 1 bit: start/resume request, sampled in IDLE and HALT.
REQ-004 The block SHALL have the port mem_ready, input, 1 bit: memory read data valid on Mdatain.
REQ-005 The block SHALL have the port IR, input, 32 bits: instruction register contents from the datapath.
REQ-006 The block SHALL have the ports PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zlowout and read, outputs, 1 bit each: datapath strobes, default 0.
REQ-007 The block SHALL have the port R_in, output, 16 bits: one-hot general-register load enables, default 0.
REQ-008 The block SHALL have the port R_out, output, 16 bits: one-hot general-register bus drives, default 0.
REQ-009 The block SHALL have the port ALU, output, 5 bits: ALU operation code, default 5'b00000.
REQ-010 The block SHALL have the port running, output, 1 bit: high in T0..T5.
REQ-011 The block SHALL have the port halted, output, 1 bit: high in HALT.
REQ-012 The block SHALL have the port illegal, output, 1 bit: one-cycle pulse on an undefined opcode.

Function
REQ-013 The block SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5 and HALT; all outputs are decoded from the state register plus IR and are held for the full cycle.
REQ-014 In IDLE, the block SHALL drive all strobes to 0 and move to T0 on the next edge when run=1.
REQ-015 In T0, the block SHALL assert PCout, MARin, IncPC and Zlowin, then move to T1.
REQ-016 In T1, the block SHALL assert read and MDRin; it SHALL stay in T1 while mem_ready=0.
REQ-017 On the T1 edge with mem_ready=1, the block SHALL also assert Zlowout and PCin and move to T2; PCin SHALL be asserted exactly once per fetch regardless of wait length.
REQ-018 In T2, the block SHALL assert MDRout and IRin, then move to T3.
REQ-019 From T3, the block SHALL decode IR: opcode=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
REQ-020 For an R-type opcode 00011..01111, T3 SHALL assert R_out[rb] and Yin.
REQ-021 For an R-type opcode, T4 SHALL assert R_out[rc] and Zlowin, with ALU = opcode - 5'b00010 (e.g. ROR 01010 -> 01000).
REQ-022 For an R-type opcode, T5 SHALL assert Zlowout and R_in[ra], then move to T0.
REQ-023 ALU SHALL hold the decoded code from T4 through T5 and SHALL be 5'b00000 in all other states.
REQ-024 Opcode 11000 (nop) SHALL go T3 -> T0 with no strobes asserted.
REQ-025 Opcode 11011 (halt) SHALL go T3 -> HALT.
REQ-026 In HALT, all strobes SHALL be 0 and halted=1; run=1 SHALL move to T0.
REQ-027 Any other opcode SHALL pulse illegal in T3 and go to T0 without writing a register.
REQ-028 When ra=rb or rb=rc, behaviour SHALL be unchanged: one-hot selects only, never multi-hot.
REQ-029 At most one of PCout, MDRout, Zlowout or any R_out bit SHALL be high in any cycle (single bus driver).

Reset
REQ-030 clear=0 SHALL immediately, without a clock, force IDLE and all outputs to 0 (ALU=0, R_in=R_out=0, running=halted=illegal=0).
REQ-031 Reset SHALL be honoured in any state, including mid-T1 wait or T4; after clear returns high, the block SHALL remain in IDLE until run=1.

Verification
REQ-032 The bench SHALL check: clear=0 then 1, run=0 for 5 cycles -> all outputs 0, state IDLE.
REQ-033 The bench SHALL check: run=1, mem_ready=1, IR=0x53320000 (ROR R6,R6,R4) -> T0 PCout/MARin/IncPC/Zlowin; T1 read/MDRin/Zlowout/PCin; T2 MDRout/IRin; T3 R_out=0x0040, Yin; T4 R_out=0x0010, ALU=01000, Zlowin; T5 Zlowout, R_in=0x0040; next cycle T0.
REQ-034 The bench SHALL check: mem_ready held 0 for 3 cycles in T1 -> read and MDRin high for 4 cycles, PCin high only on the final cycle, then T2.
REQ-035 The bench SHALL check: IR=0xD8000000 (halt) -> HALT after T3 and halted=1; run=1 -> T0 next edge.
REQ-036 The bench SHALL check: IR=0xF8000000 (undefined) -> illegal pulses 1 cycle in T3, R_in stays 0, then T0.
REQ-037 The bench SHALL check: clear=0 asserted in T4 -> outputs 0 within the same cycle (before the next edge), Zlowin deasserted, IDLE after release.
